rm_seq_monitor: RTL and testbench

Runtime-monitor array that generalises the per-lane rule check into temporal sequence rules. Each lane evaluates NUM_RULES programmable "event A, then event B within W cycles" rules over the events of its monitored instruction slots. Violations raise sticky per-lane/rule flags and are queued as alerts on a valid/ready channel toward the RM interrupt/trace logic.

---
 rtl/rm_pkg.sv | 26 ++
 rtl/rm_seq_rule.sv | 91 +++++++++
 rtl/rm_seq_monitor.sv | 183 ++++++++++++++++++
 tb/tb_rm_seq_monitor.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rm_pkg.sv
// Shared types and sizing for the runtime sequence-monitor array.
package rm_pkg;

  localparam int NUM_LANES         = 5;
  localparam int NUM_EVENTS        = 10;
  localparam int NUM_MONITORED_INS = 2;
  localparam int NUM_RULES         = 5;
  localparam int WIN_W             = 8;
  localparam int VIOL_CNT_W        = 16;

  localparam int EVT_IDX_W  = $clog2(NUM_EVENTS);
  localparam int LANE_IDX_W = $clog2(NUM_LANES);
  localparam int RULE_IDX_W = $clog2(NUM_RULES);

  typedef enum logic {
    IDLE,
    ARMED
  } rule_state_e;

  typedef struct packed {
    logic [EVT_IDX_W-1:0] evt_a;
    logic [EVT_IDX_W-1:0] evt_b;
    logic [WIN_W-1:0]     win;
  } rule_cfg_t;

endpackage

// File: rtl/rm_seq_rule.sv
// One "event A, then event B within win cycles" rule FSM with its window timer.
//
//   state | meaning
//   IDLE  | no recent A; B is harmless
//   ARMED | A seen within the last win cycles; B now is a violation
module rm_seq_rule
  import rm_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NUM_EVENTS-1:0] ev,
  input  rule_cfg_t             cfg,
  input  logic                  en,
  input  logic                  clr,
  output logic                  viol
);

  // Event indices beyond NUM_EVENTS land in the zero padding and never fire.
  localparam int EV_PAD_W = 1 << EVT_IDX_W;

  logic [EV_PAD_W-1:0] ev_pad;
  logic                a;
  logic                b;
  logic                win_zero;
  rule_state_e         state_q;
  rule_state_e         state_d;
  logic [WIN_W-1:0]    timer_q;
  logic [WIN_W-1:0]    timer_d;

  assign ev_pad   = EV_PAD_W'(ev);
  assign a        = ev_pad[cfg.evt_a];
  assign b        = ev_pad[cfg.evt_b];
  assign win_zero = (cfg.win == '0);

  // State and window timer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Next state, timer update and violation strobe; a disabled lane holds everything.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    viol    = 1'b0;
    if (clr) begin
      state_d = IDLE;
      timer_d = '0;
    end else if (en) begin
      case (state_q)
        IDLE: begin
          if (a && !win_zero) begin
            state_d = ARMED;
            timer_d = cfg.win;
          end
        end
        ARMED: begin
          if (win_zero) begin
            state_d = IDLE;
            timer_d = '0;
          end else if (b) begin
            viol = 1'b1;
            if (a) begin
              timer_d = cfg.win;
            end else begin
              state_d = IDLE;
              timer_d = '0;
            end
          end else if (a) begin
            timer_d = cfg.win;
          end else if (timer_q == WIN_W'(1)) begin
            state_d = IDLE;
            timer_d = '0;
          end else begin
            timer_d = timer_q - WIN_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/rm_seq_monitor.sv
// Sequence-rule monitor array: per-lane rule FSMs, sticky flags, pending
// alerts and a lowest-lane/lowest-rule alert arbiter on a valid/ready port.
// Build option: define RM_VIOL_CNT_EN to get saturating per-lane violation
// counters; otherwise viol_cnt_o is tied to zero.
module rm_seq_monitor
  import rm_pkg::*;
#(
  parameter int CNT_W = VIOL_CNT_W
) (
  input  logic                                                         clk_i,
  input  logic                                                         rst_ni,
  input  logic [NUM_LANES-1:0][NUM_MONITORED_INS-1:0][NUM_EVENTS-1:0] lane_vector_i,
  input  logic [NUM_LANES-1:0]                                         lane_en_i,
  input  logic [NUM_LANES-1:0]                                         lane_reset_i,
  input  logic [NUM_RULES-1:0][EVT_IDX_W-1:0]                          rule_evt_a_i,
  input  logic [NUM_RULES-1:0][EVT_IDX_W-1:0]                          rule_evt_b_i,
  input  logic [NUM_RULES-1:0][WIN_W-1:0]                              rule_win_i,
  output logic [NUM_LANES-1:0][NUM_RULES-1:0]                          monitor_o,
  output logic                                                         alert_valid_o,
  input  logic                                                         alert_ready_i,
  output logic [LANE_IDX_W-1:0]                                        alert_lane_o,
  output logic [RULE_IDX_W-1:0]                                        alert_rule_o,
  output logic                                                         alert_drop_o,
  output logic [NUM_LANES-1:0][CNT_W-1:0]                              viol_cnt_o
);

  logic [NUM_LANES-1:0][NUM_EVENTS-1:0] lane_ev;
  rule_cfg_t [NUM_RULES-1:0]            cfg;
  logic [NUM_LANES-1:0][NUM_RULES-1:0]  viol;
  logic [NUM_LANES-1:0][NUM_RULES-1:0]  accept_mask;
  logic [NUM_LANES-1:0][NUM_RULES-1:0]  cand;
  logic [NUM_LANES-1:0][NUM_RULES-1:0]  pending_q;
  logic [NUM_LANES-1:0][NUM_RULES-1:0]  pending_d;
  logic [NUM_LANES-1:0][NUM_RULES-1:0]  monitor_q;
  logic [NUM_LANES-1:0][NUM_RULES-1:0]  monitor_d;
  logic                                 handshake;
  logic                                 drop_d;
  logic                                 drop_q;
  logic                                 found;
  logic [LANE_IDX_W-1:0]                sel_lane;
  logic [RULE_IDX_W-1:0]                sel_rule;
  logic                                 alert_valid_q;
  logic [LANE_IDX_W-1:0]                alert_lane_q;
  logic [RULE_IDX_W-1:0]                alert_rule_q;

  assign handshake = alert_valid_q && alert_ready_i;

  // Collapse the monitored slots of each lane into one event vector.
  always_comb begin
    lane_ev = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      for (int s = 0; s < NUM_MONITORED_INS; s++) begin
        lane_ev[l] = lane_ev[l] | lane_vector_i[l][s];
      end
    end
  end

  for (genvar gr = 0; gr < NUM_RULES; gr++) begin : g_cfg
    assign cfg[gr] = '{evt_a: rule_evt_a_i[gr], evt_b: rule_evt_b_i[gr], win: rule_win_i[gr]};
  end

  for (genvar gl = 0; gl < NUM_LANES; gl++) begin : g_lane
    for (genvar gr = 0; gr < NUM_RULES; gr++) begin : g_rule
      rm_seq_rule u_rule (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .ev     (lane_ev[gl]),
        .cfg    (cfg[gr]),
        .en     (lane_en_i[gl]),
        .clr    (lane_reset_i[gl]),
        .viol   (viol[gl][gr])
      );
    end
  end

  // Sticky flags, pending set/clear, drop detection and arbiter pick.
  // The pair being accepted is excluded so a same-cycle violation re-pends
  // it without a drop, and lanes under reset are never picked.
  always_comb begin
    accept_mask = '0;
    cand        = '0;
    pending_d   = pending_q;
    monitor_d   = monitor_q;
    drop_d      = 1'b0;
    found       = 1'b0;
    sel_lane    = '0;
    sel_rule    = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      for (int r = 0; r < NUM_RULES; r++) begin
        accept_mask[l][r] = handshake && (alert_lane_q == LANE_IDX_W'(l))
                            && (alert_rule_q == RULE_IDX_W'(r));
      end
      if (lane_reset_i[l]) begin
        pending_d[l] = '0;
        monitor_d[l] = '0;
      end else begin
        cand[l]      = pending_q[l] & ~accept_mask[l];
        drop_d       = drop_d | (|(viol[l] & cand[l]));
        pending_d[l] = cand[l] | viol[l];
        monitor_d[l] = monitor_q[l] | viol[l];
      end
    end
    for (int l = 0; l < NUM_LANES; l++) begin
      for (int r = 0; r < NUM_RULES; r++) begin
        if (!found && cand[l][r]) begin
          found    = 1'b1;
          sel_lane = LANE_IDX_W'(l);
          sel_rule = RULE_IDX_W'(r);
        end
      end
    end
  end

  // Flag registers and the presented alert; the alert is held until accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q     <= '0;
      monitor_q     <= '0;
      drop_q        <= 1'b0;
      alert_valid_q <= 1'b0;
      alert_lane_q  <= '0;
      alert_rule_q  <= '0;
    end else begin
      pending_q <= pending_d;
      monitor_q <= monitor_d;
      drop_q    <= drop_d;
      if (!alert_valid_q || alert_ready_i) begin
        alert_valid_q <= found;
        if (found) begin
          alert_lane_q <= sel_lane;
          alert_rule_q <= sel_rule;
        end
      end
    end
  end

  assign monitor_o     = monitor_q;
  assign alert_valid_o = alert_valid_q;
  assign alert_lane_o  = alert_lane_q;
  assign alert_rule_o  = alert_rule_q;
  assign alert_drop_o  = drop_q;

`ifdef RM_VIOL_CNT_EN
  localparam int SUM_W = CNT_W + RULE_IDX_W;

  logic [NUM_LANES-1:0][CNT_W-1:0] cnt_q;
  logic [NUM_LANES-1:0][CNT_W-1:0] cnt_d;
  logic [SUM_W-1:0]                sum;

  // Add this cycle's violation count per lane, saturating at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    sum   = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      sum = SUM_W'(cnt_q[l]);
      for (int r = 0; r < NUM_RULES; r++) begin
        sum = sum + SUM_W'(viol[l][r]);
      end
      if (lane_reset_i[l]) begin
        cnt_d[l] = '0;
      end else if (|sum[SUM_W-1:CNT_W]) begin
        cnt_d[l] = '1;
      end else begin
        cnt_d[l] = sum[CNT_W-1:0];
      end
    end
  end

  // Violation counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign viol_cnt_o = cnt_q;
`else
  assign viol_cnt_o = '0;
`endif

endmodule

// File: tb/tb_rm_seq_monitor.sv
// Directed bench for rm_seq_monitor with an alert scoreboard.
module tb_rm_seq_monitor;
  import rm_pkg::*;

  localparam int TB_CNT_W = 2;
  localparam int CNT_MAX  = 3;

  logic clk_i;
  logic rst_ni;
  logic [NUM_LANES-1:0][NUM_MONITORED_INS-1:0][NUM_EVENTS-1:0] lane_vector;
  logic [NUM_LANES-1:0]                lane_en;
  logic [NUM_LANES-1:0]                lane_reset;
  logic [NUM_RULES-1:0][EVT_IDX_W-1:0] evt_a;
  logic [NUM_RULES-1:0][EVT_IDX_W-1:0] evt_b;
  logic [NUM_RULES-1:0][WIN_W-1:0]     win;
  logic [NUM_LANES-1:0][NUM_RULES-1:0] monitor;
  logic                                alert_valid;
  logic                                alert_ready;
  logic [LANE_IDX_W-1:0]               alert_lane;
  logic [RULE_IDX_W-1:0]               alert_rule;
  logic                                alert_drop;
  logic [NUM_LANES-1:0][TB_CNT_W-1:0]  viol_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int drop_seen = 0;
  logic [NUM_LANES-1:0][NUM_RULES-1:0]     mon_exp;
  int                                      cnt_exp [NUM_LANES];
  logic [LANE_IDX_W+RULE_IDX_W-1:0]        sb_q [$];

  rm_seq_monitor #(.CNT_W(TB_CNT_W)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .lane_vector_i (lane_vector),
    .lane_en_i     (lane_en),
    .lane_reset_i  (lane_reset),
    .rule_evt_a_i  (evt_a),
    .rule_evt_b_i  (evt_b),
    .rule_win_i    (win),
    .monitor_o     (monitor),
    .alert_valid_o (alert_valid),
    .alert_ready_i (alert_ready),
    .alert_lane_o  (alert_lane),
    .alert_rule_o  (alert_rule),
    .alert_drop_o  (alert_drop),
    .viol_cnt_o    (viol_cnt)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
      lane_vector = '0;
    end
  endtask

  task automatic ev(input int l, input int s, input int e);
    lane_vector[l][s][e] = 1'b1;
  endtask

  task automatic note_viol(input int l, input int r);
    mon_exp[l][r] = 1'b1;
`ifdef RM_VIOL_CNT_EN
    if (cnt_exp[l] < CNT_MAX) cnt_exp[l] = cnt_exp[l] + 1;
`endif
  endtask

  task automatic expect_alert(input int l, input int r);
    sb_q.push_back({LANE_IDX_W'(l), RULE_IDX_W'(r)});
  endtask

  task automatic reset_lane_model(input int l);
    mon_exp[l] = '0;
    cnt_exp[l] = 0;
  endtask

  // Scoreboard: every accepted alert must match the oldest expected pair.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1) begin
      if (alert_drop === 1'b1) drop_seen++;
      if (alert_valid === 1'b1 && alert_ready === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("alert_unexpected", 32'(alert_valid), 32'd0);
        end else begin
          chk("alert_pair", 32'({alert_lane, alert_rule}), 32'(sb_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_ni      = 1'b0;
    lane_vector = '0;
    lane_en     = '1;
    lane_reset  = '0;
    alert_ready = 1'b0;
    mon_exp     = '0;
    for (int i = 0; i < NUM_LANES; i++) cnt_exp[i] = 0;
    // rule0: 3->5 w4, rule1: 1->2 w6, rule2: 7->8 w3,
    // rule3: out-of-range A, rule4: window 0 (disabled)
    evt_a[0] = 4'd3;  evt_b[0] = 4'd5; win[0] = 8'd4;
    evt_a[1] = 4'd1;  evt_b[1] = 4'd2; win[1] = 8'd6;
    evt_a[2] = 4'd7;  evt_b[2] = 4'd8; win[2] = 8'd3;
    evt_a[3] = 4'd15; evt_b[3] = 4'd0; win[3] = 8'd5;
    evt_a[4] = 4'd9;  evt_b[4] = 4'd4; win[4] = 8'd0;

    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_monitor", 32'(monitor), 32'd0);
    chk("rst_valid", 32'(alert_valid), 32'd0);
    chk("rst_lane", 32'(alert_lane), 32'd0);
    chk("rst_rule", 32'(alert_rule), 32'd0);
    chk("rst_drop", 32'(alert_drop), 32'd0);
    chk("rst_cnt", 32'(viol_cnt), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step(2);

    // A: B exactly win cycles after A on lane 2
    ev(2, 0, 3); step();
    step(3);
    ev(2, 1, 5); note_viol(2, 0); expect_alert(2, 0); step();
    chk("a_mon", 32'(monitor[2][0]), 32'd1);
    chk("a_valid_early", 32'(alert_valid), 32'd0);
    ev(2, 0, 5); step();
    chk("a_valid", 32'(alert_valid), 32'd1);
    chk("a_lane", 32'(alert_lane), 32'd2);
    chk("a_rule", 32'(alert_rule), 32'd0);
    alert_ready = 1'b1; step(); alert_ready = 1'b0;
    step(3);
    chk("a_no_second", 32'(alert_valid), 32'd0);

    // B: late B, same-cycle A+B from IDLE, disabled and unreachable rules
    ev(2, 0, 3); step();
    step(4);
    ev(2, 0, 5); step();
    step(3);
    chk("b_late", 32'(alert_valid), 32'd0);
    ev(2, 0, 3); ev(2, 1, 5); step();
    step(6);
    chk("b_same_cycle", 32'(alert_valid), 32'd0);
    ev(0, 0, 9); step();
    ev(0, 0, 4); step();
    ev(2, 0, 0); step();
    step(3);
    chk("b_disabled", 32'(alert_valid), 32'd0);
    chk("b_mon2", 32'(monitor[2]), 32'(mon_exp[2]));

    // Re-arm: A with B violates and restarts the window
    alert_ready = 1'b1;
    ev(0, 0, 3); step();
    step();
    ev(0, 0, 3); ev(0, 1, 5); note_viol(0, 0); expect_alert(0, 0); step();
    step(3);
    ev(0, 0, 5); note_viol(0, 0); expect_alert(0, 0); step();
    step(4);
    alert_ready = 1'b0;
    chk("r_idle", 32'(alert_valid), 32'd0);

    // C: lanes 1 and 3 violate rule 2 together, consumer stalls
    ev(1, 1, 7); ev(3, 0, 7); step();
    ev(1, 0, 8); ev(3, 1, 8);
    note_viol(1, 2); expect_alert(1, 2);
    note_viol(3, 2); expect_alert(3, 2);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      chk("c_hold_valid", 32'(alert_valid), 32'd1);
      chk("c_hold_lane", 32'(alert_lane), 32'd1);
      chk("c_hold_rule", 32'(alert_rule), 32'd2);
      step();
    end
    alert_ready = 1'b1; step(); alert_ready = 1'b0;
    chk("c_next_valid", 32'(alert_valid), 32'd1);
    chk("c_next_lane", 32'(alert_lane), 32'd3);
    chk("c_next_rule", 32'(alert_rule), 32'd2);
    alert_ready = 1'b1; step(); alert_ready = 1'b0;
    chk("c_drained", 32'(alert_valid), 32'd0);

    // D: second violation of an unaccepted pair is dropped
    ev(0, 0, 1); step();
    ev(0, 0, 2); note_viol(0, 1); expect_alert(0, 1); step();
    ev(0, 1, 1); step();
    ev(0, 1, 2); note_viol(0, 1); step();
    chk("d_drop", 32'(alert_drop), 32'd1);
    chk("d_valid", 32'(alert_valid), 32'd1);
    chk("d_lane", 32'(alert_lane), 32'd0);
    chk("d_rule", 32'(alert_rule), 32'd1);
    step();
    chk("d_drop_clear", 32'(alert_drop), 32'd0);
    alert_ready = 1'b1; step(); alert_ready = 1'b0;
    step(2);
    chk("d_single", 32'(alert_valid), 32'd0);

    // E: lane reset with an alert presented and another pending
    ev(4, 0, 3); ev(4, 0, 7); step();
    ev(4, 1, 5); ev(4, 1, 8); ev(4, 0, 3);
    note_viol(4, 0); expect_alert(4, 0); note_viol(4, 2);
    step();
    step();
    chk("e_valid", 32'(alert_valid), 32'd1);
    chk("e_lane", 32'(alert_lane), 32'd4);
    chk("e_rule", 32'(alert_rule), 32'd0);
    chk("e_mon", 32'(monitor[4]), 32'(mon_exp[4]));
    chk("e_cnt", 32'(viol_cnt[4]), 32'(cnt_exp[4]));
    lane_reset[4] = 1'b1; reset_lane_model(4); step(); lane_reset = '0;
    chk("e_mon_clr", 32'(monitor[4]), 32'(mon_exp[4]));
    chk("e_cnt_clr", 32'(viol_cnt[4]), 32'(cnt_exp[4]));
    chk("e_valid_kept", 32'(alert_valid), 32'd1);
    chk("e_lane_kept", 32'(alert_lane), 32'd4);
    ev(4, 0, 5); step();
    alert_ready = 1'b1; step(); alert_ready = 1'b0;
    step(2);
    chk("e_no_alert", 32'(alert_valid), 32'd0);
    chk("e_mon_after", 32'(monitor[4]), 32'(mon_exp[4]));

    // F: five spaced violations on lane 1 for counter saturation
    alert_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ev(1, 0, 3); step();
      ev(1, 0, 5); note_viol(1, 0); expect_alert(1, 0); step();
      step(2);
    end
    alert_ready = 1'b0;
    step(2);
    chk("f_cnt", 32'(viol_cnt[1]), 32'(cnt_exp[1]));

    // G: disabled lane masks events and freezes its timer
    lane_en[2] = 1'b0;
    ev(2, 0, 3); step();
    lane_en[2] = 1'b1;
    ev(2, 0, 5); step();
    step(3);
    chk("g_masked_arm", 32'(alert_valid), 32'd0);
    ev(3, 0, 3); step();
    lane_en[3] = 1'b0;
    step(10);
    ev(3, 0, 5); step();
    lane_en[3] = 1'b1;
    step(2);
    ev(3, 0, 5); note_viol(3, 0); expect_alert(3, 0); step();
    alert_ready = 1'b1; step(3); alert_ready = 1'b0;
    step(2);

    chk("fin_monitor", 32'(monitor), 32'(mon_exp));
    for (int l = 0; l < NUM_LANES; l++) chk("fin_cnt", 32'(viol_cnt[l]), 32'(cnt_exp[l]));
    chk("fin_drops", 32'(drop_seen), 32'd1);
    chk("fin_sb_left", 32'(sb_q.size()), 32'd0);
    chk("fin_valid", 32'(alert_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
